// File: rtl/uart_rx_pkg.sv
// Shared UART frame constants, receiver FSM state type and received-byte payload.
package uart_rx_pkg;

    localparam int unsigned DATA_BITS          = 8;
    localparam int unsigned BITC_W             = 4;
    localparam int unsigned BAUD_COUNT_DEFAULT = 104;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_DATA    = 3'd2,
        ST_STOP    = 3'd3,
        ST_WAIT_HI = 3'd4
    } state_e;

    typedef struct packed {
        logic [DATA_BITS-1:0] data;
        logic                 frame_err;
    } rx_byte_t;

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchroniser for an asynchronous single-bit input; reset value is a parameter.
module uart_rx_sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {2{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// UART 8N1 receiver: synchronises rx, validates the start bit at mid-bit,
// samples data LSB first at mid-bit and strobes each byte for one cycle.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned BAUD_COUNT      = BAUD_COUNT_DEFAULT,
    parameter int unsigned BAUD_COUNT_SIZE = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 stb,
    output logic                 frame_err,
    output logic                 busy
);

    localparam logic [BAUD_COUNT_SIZE-1:0] BAUD_FULL = BAUD_COUNT_SIZE'(BAUD_COUNT - 1);
    localparam logic [BAUD_COUNT_SIZE-1:0] BAUD_HALF = BAUD_COUNT_SIZE'(BAUD_COUNT / 2 - 1);

    state_e                     state_q, state_d;
    logic [BAUD_COUNT_SIZE-1:0] baudc_q, baudc_d;
    logic [BITC_W-1:0]          bitc_q, bitc_d;
    logic [DATA_BITS-1:0]       shift_q, shift_d;
    rx_byte_t                   out_q, out_d;
    logic                       stb_q, stb_d;
    logic                       busy_q, busy_d;
    logic                       rx_s;
    logic                       tick;

    uart_rx_sync_2ff #(
        .RESET_VAL(1'b1)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d_i(rx),
        .q_o(rx_s)
    );

    assign tick = (baudc_q == '0);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; unreachable encodings fall back to IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (!rx_s) state_d = ST_START;
            ST_START:   if (tick) state_d = rx_s ? ST_IDLE : ST_DATA;
            ST_DATA:    if (tick && (bitc_q == BITC_W'(DATA_BITS - 1))) state_d = ST_STOP;
            ST_STOP:    if (tick) state_d = rx_s ? ST_IDLE : ST_WAIT_HI;
            ST_WAIT_HI: if (rx_s) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Datapath and output next values
    always_comb begin
        baudc_d = tick ? BAUD_FULL : (baudc_q - BAUD_COUNT_SIZE'(1));
        bitc_d  = bitc_q;
        shift_d = shift_q;
        out_d   = out_q;
        stb_d   = 1'b0;
        busy_d  = (state_d != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (!rx_s) baudc_d = BAUD_HALF;
            end
            ST_START: begin
                if (tick && !rx_s) bitc_d = '0;
            end
            ST_DATA: begin
                if (tick) begin
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    bitc_d  = bitc_q + BITC_W'(1);
                end
            end
            ST_STOP: begin
                if (tick) begin
                    out_d.data      = shift_q;
                    out_d.frame_err = ~rx_s;
                    stb_d           = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            baudc_q <= '0;
            bitc_q  <= '0;
            shift_q <= '0;
            out_q   <= '0;
            stb_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            baudc_q <= baudc_d;
            bitc_q  <= bitc_d;
            shift_q <= shift_d;
            out_q   <= out_d;
            stb_q   <= stb_d;
            busy_q  <= busy_d;
        end
    end

    assign data      = out_q.data;
    assign frame_err = out_q.frame_err;
    assign stb       = stb_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: vector table, corner-case sequences and randomised frames.
module tb_uart_rx;

    localparam int unsigned BIT = 104;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] data;
    logic       stb;
    logic       frame_err;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;
    int unsigned cyc = 0;

    logic [7:0]  cap_data[$];
    logic        cap_ferr[$];
    int unsigned cap_cyc[$];
    logic        stb_prev = 1'b0;
    int          stb_wide = 0;

    uart_rx #(.BAUD_COUNT(104), .BAUD_COUNT_SIZE(7)) dut (
        .clk(clk), .rst(rst), .rx(rx),
        .data(data), .stb(stb), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Capture every strobe, away from the active edge
    always @(negedge clk) begin
        if (stb === 1'b1) begin
            cap_data.push_back(data);
            cap_ferr.push_back(frame_err);
            cap_cyc.push_back(cyc);
            if (stb_prev) stb_wide++;
        end
        stb_prev = (stb === 1'b1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] cd(input int i);
        return (cap_data.size() > i) ? 32'(cap_data[i]) : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] cf(input int i);
        return (cap_ferr.size() > i) ? 32'(cap_ferr[i]) : 32'hFFFF_FFFF;
    endfunction

    function automatic int unsigned cc(input int i);
        return (cap_cyc.size() > i) ? cap_cyc[i] : 0;
    endfunction

    task automatic flush();
        cap_data.delete();
        cap_ferr.delete();
        cap_cyc.delete();
    endtask

    task automatic idle(input int unsigned n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input int unsigned blen, input logic stopv);
        rx = 1'b0;
        repeat (blen) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (blen) @(negedge clk);
        end
        rx = stopv;
        repeat (blen) @(negedge clk);
    endtask

    typedef struct {
        logic [7:0]  din;
        logic        stop;
        int unsigned blen;
        logic [7:0]  exp_data;
        logic        exp_ferr;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [7:0]  exp_q_d[$];
        logic        exp_q_f[$];
        logic [7:0]  b;
        logic        stopv;
        int unsigned gap;
        int unsigned t_high;
        logic        busy_seen;

        vecs[0] = '{8'h55, 1'b1, 104, 8'h55, 1'b0};
        vecs[1] = '{8'hA3, 1'b1, 104, 8'hA3, 1'b0};
        vecs[2] = '{8'h00, 1'b1, 104, 8'h00, 1'b0};
        vecs[3] = '{8'hFF, 1'b1, 104, 8'hFF, 1'b0};
        vecs[4] = '{8'h81, 1'b0, 104, 8'h81, 1'b1};
        vecs[5] = '{8'h3C, 1'b1, 101, 8'h3C, 1'b0};
        vecs[6] = '{8'hC5, 1'b1, 107, 8'hC5, 1'b0};

        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_data", 32'(data), 32'h0);
        check("reset_stb", 32'(stb), 32'h0);
        check("reset_ferr", 32'(frame_err), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        idle(20);

        // Table-driven single frames
        for (int v = 0; v < 7; v++) begin
            flush();
            send_frame(vecs[v].din, vecs[v].blen, vecs[v].stop);
            idle(2 * BIT);
            check($sformatf("vec%0d_count", v), 32'(cap_data.size()), 32'd1);
            check($sformatf("vec%0d_data", v), cd(0), 32'(vecs[v].exp_data));
            check($sformatf("vec%0d_ferr", v), cf(0), 32'(vecs[v].exp_ferr));
            check($sformatf("vec%0d_busy", v), 32'(busy), 32'h0);
        end

        // Back-to-back frames: strobes one frame time apart
        flush();
        send_frame(8'hA3, BIT, 1'b1);
        send_frame(8'h00, BIT, 1'b1);
        idle(2 * BIT);
        check("b2b_count", 32'(cap_data.size()), 32'd2);
        check("b2b_data0", cd(0), 32'hA3);
        check("b2b_data1", cd(1), 32'h00);
        check("b2b_ferr0", cf(0), 32'h0);
        check("b2b_ferr1", cf(1), 32'h0);
        gap = cc(1) - cc(0);
        n_checks++;
        if (cap_cyc.size() < 2 || gap < 1038 || gap > 1042) begin
            n_fail++;
            $display("FAIL b2b_gap: got %0d cycles, expected 1040 +/-2", gap);
        end

        // Start-bit glitch: 20 clk low is rejected
        flush();
        busy_seen = 1'b0;
        rx = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (i == 20) rx = 1'b1;
            @(negedge clk);
            busy_seen |= (busy === 1'b1);
        end
        check("glitch_busy_seen", 32'(busy_seen), 32'h1);
        check("glitch_busy_low", 32'(busy), 32'h0);
        idle(2 * BIT);
        check("glitch_no_stb", 32'(cap_data.size()), 32'd0);

        // Break then a normal frame
        flush();
        rx = 1'b0;
        repeat (12 * BIT) @(negedge clk);
        t_high = cyc;
        idle(2 * BIT);
        send_frame(8'h7E, BIT, 1'b1);
        idle(2 * BIT);
        check("break_count", 32'(cap_data.size()), 32'd2);
        check("break_data", cd(0), 32'h00);
        check("break_ferr", cf(0), 32'h1);
        check("break_stb_during_low", 32'(cc(0) < t_high && cap_cyc.size() > 0), 32'h1);
        check("after_break_data", cd(1), 32'h7E);
        check("after_break_ferr", cf(1), 32'h0);

        // Reset in bit 4 aborts the frame
        flush();
        fork
            send_frame(8'hC3, BIT, 1'b1);
            begin
                repeat (4 * BIT + BIT / 2) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check("midrst_data", 32'(data), 32'h0);
                check("midrst_stb", 32'(stb), 32'h0);
                check("midrst_ferr", 32'(frame_err), 32'h0);
                check("midrst_busy", 32'(busy), 32'h0);
                repeat (3 * BIT) @(negedge clk);
                check("midrst_no_stb", 32'(cap_data.size()), 32'd0);
            end
        join
        idle(20 * BIT);
        flush();
        send_frame(8'h3C, BIT, 1'b1);
        idle(2 * BIT);
        check("post_rst_count", 32'(cap_data.size()), 32'd1);
        check("post_rst_data", cd(0), 32'h3C);
        check("post_rst_ferr", cf(0), 32'h0);

        // Random frames at +/-3% transmitter clock, occasional bad stop bit
        flush();
        for (int k = 0; k < 32; k++) begin
            b     = 8'($urandom);
            stopv = ($urandom_range(0, 7) != 0);
            send_frame(b, $urandom_range(101, 107), stopv);
            exp_q_d.push_back(b);
            exp_q_f.push_back(~stopv);
            if (!stopv) idle(BIT);
            else idle($urandom_range(0, 60));
        end
        idle(3 * BIT);
        check("rand_count", 32'(cap_data.size()), 32'(exp_q_d.size()));
        for (int k = 0; k < exp_q_d.size(); k++) begin
            check($sformatf("rand%0d_data", k), cd(k), 32'(exp_q_d[k]));
            check($sformatf("rand%0d_ferr", k), cf(k), 32'(exp_q_f[k]));
        end

        check("stb_single_cycle", 32'(stb_wide), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
